sap_controller: RTL and testbench
=================================

SAP_CONTROLLER -- requirements
Module: sap_controller

Interface
REQ-001 SHALL have parameter OPW, default 4, meaning opcode width in bits.
REQ-002 SHALL have parameter OP_LDA/OP_ADD/OP_SUB/OP_OUT/OP_HLT, defaults 4'h0/4'h1/4'h2/4'hE/4'hF, meaning recognised opcodes.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates occur on the falling edge of clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low, sampled on the falling edge of clk.
REQ-005 SHALL have port start  input  1  begin or resume execution from IDLE.
REQ-006 SHALL have port step_mode  input  1  1 = return to IDLE after each instruction.
REQ-007 SHALL have port ir_opcode  input  OPW  upper nibble of the instruction register.
REQ-008 SHALL have ports cp, ep, ea, su, eu  output  1 each  active-high controls: PC increment, PC enable, A enable, subtract, ALU enable.
REQ-009 SHALL have ports lm_n, ce_n, li_n, ei_n, la_n, lb_n, lo_n  output  1 each  active-low controls: MAR load, RAM enable, IR load, IR enable, A/B/OUT load.
REQ-010 SHALL have port t_state  output  6  one-hot T1..T6 (bit0 = T1); 0 outside T-states.
REQ-011 SHALL have ports busy, hlt, instr_done, illegal  output  1 each  status.

Function
REQ-012 SHALL implement states IDLE, T1..T6, HALT; all control outputs are a decode of the current state and the latched opcode only (Moore).
REQ-013 SHALL, in IDLE and HALT, drive all controls inactive: cp=ep=ea=su=eu=0, all *_n=1.
REQ-014 SHALL move IDLE->T1 on a falling edge where start=1; otherwise remain IDLE.
REQ-015 SHALL advance T1->T2->...->T6 unconditionally, one clock each.
REQ-016 SHALL at T6 exit go to IDLE if step_mode=1, else T1.
REQ-017 SHALL drive T1: ep=1, lm_n=0; T2: cp=1; T3: ce_n=0, li_n=0 (all opcodes).
REQ-018 SHALL latch ir_opcode into an internal opcode register on the T3->T4 edge; T4-T6 decode uses the latched value only.
REQ-019 SHALL for LDA drive T4: ei_n=0, lm_n=0; T5: ce_n=0, la_n=0; T6: none.
REQ-020 SHALL for ADD drive T4: ei_n=0, lm_n=0; T5: ce_n=0, lb_n=0; T6: eu=1, la_n=0.
REQ-021 SHALL for SUB drive ADD's sequence plus su=1 during T6 only.
REQ-022 SHALL for OUT drive T4: ea=1, lo_n=0; T5, T6: none.
REQ-023 SHALL for HLT go T4 directly to HALT with no T4 controls; HALT exits only via reset; start ignored.
REQ-024 SHALL treat any unrecognised opcode as NOP (no controls T4-T6), assert illegal for T4-T6, and continue normally.
REQ-025 SHALL assert busy in T1..T6, hlt in HALT only, instr_done during T6 only (never for HLT).
REQ-026 SHALL never assert both ep and ea, or both ei_n=0 and eu, in one state (single bus driver).
REQ-027 SHALL ignore start and step_mode changes except at the IDLE and T6 decision points.

Reset
REQ-028 SHALL on a falling edge with rst=0 enter IDLE, clear opcode register to 0, t_state=0, busy=hlt=instr_done=illegal=0, all controls inactive, from any state including mid-instruction and HALT.
REQ-029 SHALL give reset priority over start.
REQ-030 SHALL start execution no earlier than the first falling edge after rst returns to 1 with start=1.

Verification
REQ-031 Reset mid-T5 of ADD -> next state IDLE, ce_n=lb_n=1, busy=0, t_state=6'b000000.
REQ-032 step_mode=0, start pulse, ir_opcode=4'h0 -> t_state 01,02,04,08,10,20 then 01; T1 ep=1/lm_n=0, T5 la_n=0, instr_done high only in T6.
REQ-033 ir_opcode=4'h2 -> T6 shows eu=1, su=1, la_n=0; su=0 in T1..T5.
REQ-034 ir_opcode=4'hF -> after T3, hlt=1, busy=0, controls inactive, start pulses ignored for 10 cycles; rst=0 -> IDLE.
REQ-035 ir_opcode=4'h7 -> illegal=1 in T4..T6, no controls T4..T6, instr_done=1 in T6, next T1 proceeds.
REQ-036 step_mode=1, opcode 4'hE -> T4 ea=1/lo_n=0, after T6 IDLE; ir_opcode changed during T5 has no effect on T6.

Source files
------------

// File: rtl/sap_controller.sv
// ----------------------------------------------------------------------------
// sap_controller
//
// Purpose:
//   Microsequencer for a SAP-1 style computer. Walks each instruction through
//   six T-states (fetch in T1..T3, execute in T4..T6). It drives the bus and
//   register control lines as a pure decode of the current state and the
//   opcode latched at the end of fetch. HLT parks the machine in HALT until
//   reset. Unknown opcodes execute as NOPs and are flagged.
//
// Ports:
//   clk        - single clock; every state update happens on its falling edge
//   rst        - synchronous active-low reset, sampled on the falling edge
//   start      - leaves IDLE and begins (or resumes) execution
//   step_mode  - 1 = return to IDLE after every instruction
//   ir_opcode  - upper field of the instruction register
//   cp, ep     - PC increment / PC bus enable (active high)
//   ea, su, eu - A bus enable / subtract / ALU bus enable (active high)
//   lm_n, ce_n, li_n, ei_n, la_n, lb_n, lo_n
//              - MAR load, RAM enable, IR load, IR enable, A/B/OUT load
//                (active low)
//   t_state    - one-hot T1..T6 (bit0 = T1), zero outside the T-states
//   busy       - high in T1..T6
//   hlt        - high in HALT
//   instr_done - high in T6 of every completed (non-HLT) instruction
//   illegal    - high in T4..T6 when the latched opcode is not recognised
// ----------------------------------------------------------------------------
module sap_controller #(
  parameter int OPW = 4,
  parameter logic [OPW-1:0] OP_LDA = 4'h0,
  parameter logic [OPW-1:0] OP_ADD = 4'h1,
  parameter logic [OPW-1:0] OP_SUB = 4'h2,
  parameter logic [OPW-1:0] OP_OUT = 4'hE,
  parameter logic [OPW-1:0] OP_HLT = 4'hF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           step_mode,
  input  logic [OPW-1:0] ir_opcode,
  output logic           cp,
  output logic           ep,
  output logic           ea,
  output logic           su,
  output logic           eu,
  output logic           lm_n,
  output logic           ce_n,
  output logic           li_n,
  output logic           ei_n,
  output logic           la_n,
  output logic           lb_n,
  output logic           lo_n,
  output logic [5:0]     t_state,
  output logic           busy,
  output logic           hlt,
  output logic           instr_done,
  output logic           illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] opcode_q, opcode_d;

  logic opLda, opAdd, opSub, opOut, opHlt, opKnown;

  // The machine is built around a falling-edge clock. Reset clears the state
  // and the opcode latch, and it takes priority over everything else.
  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Sequencing. The opcode is captured only on the T3->T4 edge. From that
  // point on, execution ignores the live IR. start and step_mode are read
  // only at the IDLE and T6 decision points.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        state_d  = S_T4;
        opcode_d = ir_opcode;
      end
      S_T4:   state_d = opHlt ? S_HALT : S_T5;
      S_T5:   state_d = S_T6;
      S_T6:   state_d = step_mode ? S_IDLE : S_T1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Opcode classification of the latched value.
  always_comb begin
    opLda   = (opcode_q == OP_LDA);
    opAdd   = (opcode_q == OP_ADD);
    opSub   = (opcode_q == OP_SUB);
    opOut   = (opcode_q == OP_OUT);
    opHlt   = (opcode_q == OP_HLT);
    opKnown = opLda | opAdd | opSub | opOut | opHlt;
  end

  // Moore decode of the control word. Everything starts inactive, and each
  // state pulls down or raises only the lines it needs. That keeps IDLE,
  // HALT, HLT's T4 and NOP execute states quiet by construction. Only one of
  // ep/ea/ei_n/eu is active in any state, so the bus has one driver.
  always_comb begin
    cp         = 1'b0;
    ep         = 1'b0;
    ea         = 1'b0;
    su         = 1'b0;
    eu         = 1'b0;
    lm_n       = 1'b1;
    ce_n       = 1'b1;
    li_n       = 1'b1;
    ei_n       = 1'b1;
    la_n       = 1'b1;
    lb_n       = 1'b1;
    lo_n       = 1'b1;
    t_state    = 6'b000000;
    busy       = 1'b0;
    hlt        = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_T1: begin
        t_state = 6'b000001;
        busy    = 1'b1;
        ep      = 1'b1;
        lm_n    = 1'b0;
      end
      S_T2: begin
        t_state = 6'b000010;
        busy    = 1'b1;
        cp      = 1'b1;
      end
      S_T3: begin
        t_state = 6'b000100;
        busy    = 1'b1;
        ce_n    = 1'b0;
        li_n    = 1'b0;
      end
      S_T4: begin
        t_state = 6'b001000;
        busy    = 1'b1;
        illegal = ~opKnown;
        if (opLda | opAdd | opSub) begin
          ei_n = 1'b0;
          lm_n = 1'b0;
        end else if (opOut) begin
          ea   = 1'b1;
          lo_n = 1'b0;
        end
      end
      S_T5: begin
        t_state = 6'b010000;
        busy    = 1'b1;
        illegal = ~opKnown;
        if (opLda) begin
          ce_n = 1'b0;
          la_n = 1'b0;
        end else if (opAdd | opSub) begin
          ce_n = 1'b0;
          lb_n = 1'b0;
        end
      end
      S_T6: begin
        t_state    = 6'b100000;
        busy       = 1'b1;
        instr_done = 1'b1;
        illegal    = ~opKnown;
        if (opAdd | opSub) begin
          eu   = 1'b1;
          la_n = 1'b0;
          su   = opSub;
        end
      end
      S_HALT: hlt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sap_controller.sv
// ----------------------------------------------------------------------------
// tb_sap_controller
//
// Purpose:
//   Directed self-checking bench for sap_controller. An instruction-level
//   model predicts the full control word after every falling edge. A monitor
//   compares it on each rising edge. Literal checks at chosen points pin the
//   model to hand-computed values.
// ----------------------------------------------------------------------------
module tb_sap_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic       step_mode;
  logic [3:0] ir_opcode;
  logic       cp, ep, ea, su, eu;
  logic       lm_n, ce_n, li_n, ei_n, la_n, lb_n, lo_n;
  logic [5:0] t_state;
  logic       busy, hlt, instr_done, illegal;

  int checks = 0;
  int errors = 0;

  // Model state: phase 0 = idle, 1..6 = T1..T6, 7 = halted.
  int         mPhase = 0;
  logic [3:0] mOp = 4'h0;
  logic       modelValid = 1'b0;

  sap_controller dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .step_mode  (step_mode),
    .ir_opcode  (ir_opcode),
    .cp         (cp),
    .ep         (ep),
    .ea         (ea),
    .su         (su),
    .eu         (eu),
    .lm_n       (lm_n),
    .ce_n       (ce_n),
    .li_n       (li_n),
    .ei_n       (ei_n),
    .la_n       (la_n),
    .lb_n       (lb_n),
    .lo_n       (lo_n),
    .t_state    (t_state),
    .busy       (busy),
    .hlt        (hlt),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs the control word as {cp,ep,ea,su,eu,lm_n,ce_n,li_n,ei_n,la_n,lb_n,
  // lo_n,t_state,busy,hlt,instr_done,illegal}. The value is computed from the
  // instruction tables for a given phase and opcode.
  function automatic logic [21:0] expectedVec(input int phase, input logic [3:0] op);
    logic xcp, xep, xea, xsu, xeu;
    logic xlm, xce, xli, xei, xla, xlb, xlo;
    logic [5:0] xts;
    logic known, isAlu;
    xcp = 0; xep = 0; xea = 0; xsu = 0; xeu = 0;
    xlm = 1; xce = 1; xli = 1; xei = 1; xla = 1; xlb = 1; xlo = 1;
    known = (op == 4'h0) || (op == 4'h1) || (op == 4'h2) || (op == 4'hE) || (op == 4'hF);
    isAlu = (op == 4'h1) || (op == 4'h2);
    xts = (phase >= 1 && phase <= 6) ? (6'b000001 << (phase - 1)) : 6'b000000;
    if (phase == 1) begin xep = 1; xlm = 0; end
    if (phase == 2) xcp = 1;
    if (phase == 3) begin xce = 0; xli = 0; end
    if (phase == 4 && (op == 4'h0 || isAlu)) begin xei = 0; xlm = 0; end
    if (phase == 4 && op == 4'hE) begin xea = 1; xlo = 0; end
    if (phase == 5 && op == 4'h0) begin xce = 0; xla = 0; end
    if (phase == 5 && isAlu) begin xce = 0; xlb = 0; end
    if (phase == 6 && isAlu) begin xeu = 1; xla = 0; xsu = (op == 4'h2); end
    return {xcp, xep, xea, xsu, xeu, xlm, xce, xli, xei, xla, xlb, xlo, xts,
            (phase >= 1 && phase <= 6), (phase == 7), (phase == 6),
            (phase >= 4 && phase <= 6 && !known)};
  endfunction

  // Instruction-level model that advances on the same falling edge as the DUT.
  always @(negedge clk) begin
    if (!rst) begin
      mPhase     = 0;
      mOp        = 4'h0;
      modelValid = 1'b1;
    end else if (mPhase == 0) begin
      if (start) mPhase = 1;
    end else if (mPhase == 3) begin
      mOp    = ir_opcode;
      mPhase = 4;
    end else if (mPhase == 4) begin
      mPhase = (mOp == 4'hF) ? 7 : 5;
    end else if (mPhase == 6) begin
      mPhase = step_mode ? 0 : 1;
    end else if (mPhase != 7) begin
      mPhase = mPhase + 1;
    end
  end

  // Compares the whole control word against the model on every rising edge.
  // It also checks that the bus never has two drivers.
  always @(posedge clk) begin
    logic [21:0] actual, expected;
    if (modelValid) begin
      actual = {cp, ep, ea, su, eu, lm_n, ce_n, li_n, ei_n, la_n, lb_n, lo_n,
                t_state, busy, hlt, instr_done, illegal};
      expected = expectedVec(mPhase, mOp);
      checks++;
      if (actual !== expected) begin
        errors++;
        $display("[TB] FAIL modelCompare phase=%0d op=%h actual=%h expected=%h",
                 mPhase, mOp, actual, expected);
      end
      checks++;
      if ((ep && ea) || (!ei_n && eu)) begin
        errors++;
        $display("[TB] FAIL busConflict ep=%b ea=%b ei_n=%b eu=%b expected no overlap",
                 ep, ea, ei_n, eu);
      end
    end
  end

  // Drives one set of inputs just after a rising edge. It then waits until
  // just after the next rising edge, so exactly one falling edge sees them.
  task automatic applyStimulus(input logic r, input logic s, input logic sm,
                               input logic [3:0] op);
    rst       = r;
    start     = s;
    step_mode = sm;
    ir_opcode = op;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; step_mode = 1'b0; ir_opcode = 4'h0;
    @(posedge clk);
    #1;

    // Reset, including reset winning over start.
    applyStimulus(0, 0, 0, 4'h0);
    applyStimulus(0, 1, 0, 4'h0);
    checkOutput("resetTState", 32'(t_state), 32'h0);
    checkOutput("resetBusy", 32'(busy), 32'h0);
    checkOutput("resetLmN", 32'(lm_n), 32'h1);
    checkOutput("resetHlt", 32'(hlt), 32'h0);

    // LDA with free-running execution.
    applyStimulus(1, 1, 0, 4'h0);
    checkOutput("ldaT1TState", 32'(t_state), 32'h01);
    checkOutput("ldaT1Ep", 32'(ep), 32'h1);
    checkOutput("ldaT1LmN", 32'(lm_n), 32'h0);
    applyStimulus(1, 0, 0, 4'h0);
    checkOutput("ldaT2Cp", 32'(cp), 32'h1);
    applyStimulus(1, 0, 0, 4'h0);
    checkOutput("ldaT3LiN", 32'(li_n), 32'h0);
    applyStimulus(1, 0, 0, 4'h0);
    checkOutput("ldaT4EiN", 32'(ei_n), 32'h0);
    applyStimulus(1, 0, 0, 4'h2);
    checkOutput("ldaT5TState", 32'(t_state), 32'h10);
    checkOutput("ldaT5LaN", 32'(la_n), 32'h0);
    checkOutput("ldaT5Done", 32'(instr_done), 32'h0);
    applyStimulus(1, 0, 0, 4'h2);
    checkOutput("ldaT6Done", 32'(instr_done), 32'h1);
    checkOutput("ldaT6LaN", 32'(la_n), 32'h1);

    // SUB follows immediately.
    applyStimulus(1, 0, 0, 4'h2);
    checkOutput("subT1TState", 32'(t_state), 32'h01);
    applyStimulus(1, 0, 0, 4'h2);
    applyStimulus(1, 0, 0, 4'h2);
    applyStimulus(1, 0, 0, 4'h2);
    applyStimulus(1, 0, 0, 4'h2);
    checkOutput("subT5Su", 32'(su), 32'h0);
    checkOutput("subT5LbN", 32'(lb_n), 32'h0);
    applyStimulus(1, 0, 0, 4'h7);
    checkOutput("subT6EuSuLaN", 32'({eu, su, la_n}), 32'h6);

    // Illegal opcode 7 runs as a NOP.
    applyStimulus(1, 0, 0, 4'h7);
    applyStimulus(1, 0, 0, 4'h7);
    applyStimulus(1, 0, 0, 4'h7);
    applyStimulus(1, 0, 0, 4'h7);
    checkOutput("illT4Illegal", 32'(illegal), 32'h1);
    checkOutput("illT4EiN", 32'(ei_n), 32'h1);
    applyStimulus(1, 0, 0, 4'h7);
    applyStimulus(1, 0, 0, 4'h1);
    checkOutput("illT6Done", 32'({instr_done, illegal}), 32'h3);
    applyStimulus(1, 0, 0, 4'h1);
    checkOutput("illNextT1", 32'(t_state), 32'h01);

    // ADD is reset in the middle of T5.
    applyStimulus(1, 0, 0, 4'h1);
    applyStimulus(1, 0, 0, 4'h1);
    applyStimulus(1, 0, 0, 4'h1);
    applyStimulus(1, 0, 0, 4'h1);
    checkOutput("addT5LbN", 32'(lb_n), 32'h0);
    applyStimulus(0, 0, 0, 4'h1);
    checkOutput("midResetTState", 32'(t_state), 32'h0);
    checkOutput("midResetCeLb", 32'({ce_n, lb_n, busy}), 32'h6);
    applyStimulus(1, 0, 0, 4'h1);

    // OUT in step mode; changing the IR during T5 must not affect T6.
    applyStimulus(1, 1, 1, 4'hE);
    applyStimulus(1, 0, 1, 4'hE);
    applyStimulus(1, 0, 1, 4'hE);
    applyStimulus(1, 0, 1, 4'hE);
    checkOutput("outT4EaLoN", 32'({ea, lo_n}), 32'h2);
    applyStimulus(1, 0, 1, 4'hE);
    applyStimulus(1, 0, 1, 4'h2);
    checkOutput("outT6Quiet", 32'({eu, su, la_n, instr_done}), 32'h3);
    applyStimulus(1, 0, 1, 4'h2);
    checkOutput("stepIdle", 32'({t_state, busy}), 32'h0);

    // HLT parks the machine, start is ignored, and only reset leaves HALT.
    applyStimulus(1, 1, 0, 4'hF);
    applyStimulus(1, 0, 0, 4'hF);
    applyStimulus(1, 0, 0, 4'hF);
    applyStimulus(1, 0, 0, 4'hF);
    checkOutput("hltT4", 32'({t_state, hlt}), 32'h10);
    applyStimulus(1, 0, 0, 4'hF);
    checkOutput("haltState", 32'({hlt, busy, t_state}), 32'h80);
    for (int i = 0; i < 10; i++) applyStimulus(1, (i % 2 == 0), 0, 4'hF);
    checkOutput("haltHolds", 32'({hlt, busy, lm_n}), 32'h5);
    applyStimulus(0, 1, 0, 4'hF);
    checkOutput("haltReset", 32'({hlt, t_state}), 32'h0);
    applyStimulus(1, 0, 0, 4'h0);
    applyStimulus(1, 0, 0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
